axi_bw_response_arbiter: RTL and testbench

- Downstream neighbour of the B-channel address decoder, one instance per target (slave-side) port of the node.
- Collects write-response requests that the N_INIT_PORT per-initiator decoders route to this target, and arbitrates them round-robin.
- Strips the node routing bits from BID and presents one registered AXI B channel to the target port.
- Provides full throughput: one response per cycle when the downstream sink is always ready.

---
 rtl/axi_node_pkg.sv | 15 +
 rtl/axi_rr_arb.sv | 43 ++++
 rtl/axi_bw_response_arbiter.sv | 95 +++++++++
 tb/tb_axi_bw_response_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node: BRESP encodings and the routing-width helper
// used to size initiator-side IDs.
package axi_node_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Width of a source index; a single source still needs one bit.
   function automatic int route_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_rr_arb.sv
// Combinational N-way round-robin arbiter: the search starts at ptr_i and wraps.
// Produces a one-hot (or zero) grant plus its binary index.
module axi_rr_arb
   import axi_node_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = route_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   // ptr_i < N and k < N, so one conditional subtraction is a full modulo.
   function automatic logic [IW-1:0] wrap_idx(input int v);
      return (v >= N) ? IW'(v - N) : IW'(v);
   endfunction

   logic [IW-1:0] sel_s;
   logic          found_s;

   // First requester at or after the pointer wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_s = 1'b0;
      sel_s   = '0;
      for (int k = 0; k < N; k++) begin
         sel_s = wrap_idx(int'(ptr_i) + k);
         if (!found_s && req_i[sel_s]) begin
            gnt_o[sel_s] = 1'b1;
            idx_o        = sel_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      vld_o = found_s;
   end

endmodule

// File: rtl/axi_bw_response_arbiter.sv
// Per-target B-channel arbiter: round-robin over the initiator-side decoders, strips the
// routing bits from BID and drives one registered B channel toward the target port.
module axi_bw_response_arbiter
   import axi_node_pkg::*;
#(
   parameter int N_INIT_PORT = 4,
   parameter int AXI_ID_IN   = 3,
   parameter int AXI_ID_OUT  = AXI_ID_IN + route_w(N_INIT_PORT),
   parameter int AXI_USER_W  = 6
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
   input  logic [N_INIT_PORT*2-1:0]          bresp_i,
   input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
   input  logic [N_INIT_PORT-1:0]            bvalid_i,
   output logic [N_INIT_PORT-1:0]            bready_o,
   output logic [AXI_ID_IN-1:0]              bid_o,
   output logic [1:0]                        bresp_o,
   output logic [AXI_USER_W-1:0]             buser_o,
   output logic                              bvalid_o,
   input  logic                              bready_i
);

   localparam int IW = route_w(N_INIT_PORT);

   logic [N_INIT_PORT-1:0] gnt_s;
   logic [IW-1:0]          win_s;
   logic                   win_vld_s;
   logic                   load_en_s;

   logic [IW-1:0]          rr_q,     rr_d;
   logic                   bvalid_q, bvalid_d;
   logic [AXI_ID_IN-1:0]   bid_q,    bid_d;
   logic [1:0]             bresp_q,  bresp_d;
   logic [AXI_USER_W-1:0]  buser_q,  buser_d;

   axi_rr_arb #(
      .N  (N_INIT_PORT),
      .IW (IW)
   ) u_arb (
      .req_i (bvalid_i),
      .ptr_i (rr_q),
      .gnt_o (gnt_s),
      .idx_o (win_s),
      .vld_o (win_vld_s)
   );

   // rst_n gates the ready so no decoder sees a handshake while the node is held in reset.
   assign load_en_s = rst_n & (~bvalid_q | bready_i);
   assign bready_o  = gnt_s & {N_INIT_PORT{load_en_s}};

   // Next state of the output register and the round-robin pointer.
   always_comb begin
      rr_d     = rr_q;
      bvalid_d = bvalid_q;
      bid_d    = bid_q;
      bresp_d  = bresp_q;
      buser_d  = buser_q;
      if (win_vld_s && load_en_s) begin
         bvalid_d = 1'b1;
         bid_d    = bid_i[int'(win_s)*AXI_ID_OUT +: AXI_ID_IN];
         bresp_d  = bresp_i[int'(win_s)*2 +: 2];
         buser_d  = buser_i[int'(win_s)*AXI_USER_W +: AXI_USER_W];
         rr_d     = (win_s == IW'(N_INIT_PORT - 1)) ? '0 : win_s + IW'(1);
      end else if (bready_i) begin
         bvalid_d = 1'b0;
      end else begin
         bvalid_d = bvalid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= '0;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         bresp_q  <= 2'b00;
         buser_q  <= '0;
      end else begin
         rr_q     <= rr_d;
         bvalid_q <= bvalid_d;
         bid_q    <= bid_d;
         bresp_q  <= bresp_d;
         buser_q  <= buser_d;
      end
   end

   assign bvalid_o = bvalid_q;
   assign bid_o    = bid_q;
   assign bresp_o  = bresp_q;
   assign buser_o  = buser_q;

endmodule

// File: tb/tb_axi_bw_response_arbiter.sv
// Self-checking bench for axi_bw_response_arbiter: directed table, hand sequences for
// backpressure and reset, then random traffic against a behavioural model.
module tb_axi_bw_response_arbiter;

   localparam int N  = 4;
   localparam int II = 3;
   localparam int IO = 5;
   localparam int UW = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0][IO-1:0] bid_a;
   logic [N-1:0][1:0]    resp_a;
   logic [N-1:0][UW-1:0] user_a;
   logic [N-1:0]         bvalid_i;
   logic [N-1:0]         bready_o;
   logic [II-1:0]        bid_o;
   logic [1:0]           bresp_o;
   logic [UW-1:0]        buser_o;
   logic                 bvalid_o;
   logic                 bready_i;

   always #5 clk = ~clk;

   axi_bw_response_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bid_i    (bid_a),
      .bresp_i  (resp_a),
      .buser_i  (user_a),
      .bvalid_i (bvalid_i),
      .bready_o (bready_o),
      .bid_o    (bid_o),
      .bresp_o  (bresp_o),
      .buser_o  (buser_o),
      .bvalid_o (bvalid_o),
      .bready_i (bready_i)
   );

   int n_tot = 0;
   int n_pass = 0;

   // Reference model state.
   bit          m_valid;
   int          m_rr;
   logic [2:0]  m_id;
   logic [1:0]  m_resp;
   logic [5:0]  m_user;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Winner = valid source with the smallest forward distance from the pointer.
   function automatic int pick(input logic [N-1:0] v, input int rr);
      int best = -1;
      int bd = N;
      for (int i = 0; i < N; i++)
         if (v[i] && ((i - rr + N) % N) < bd) begin
            bd = (i - rr + N) % N;
            best = i;
         end
      return best;
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0; m_rr = 0; m_id = 3'd0; m_resp = 2'd0; m_user = 6'd0;
   endfunction

   // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
   task automatic tick(input bit use_model, output logic [N-1:0] br_seen);
      int w;
      bit ld;
      @(negedge clk);
      ld = rst_n && (!m_valid || bready_i);
      w = pick(bvalid_i, m_rr);
      br_seen = bready_o;
      if (use_model) chk("bready_o", 32'(bready_o), (ld && w >= 0) ? (32'd1 << w) : 32'd0);
      @(posedge clk);
      if (ld && w >= 0) begin
         m_valid = 1'b1;
         m_id = bid_a[w][2:0];
         m_resp = resp_a[w];
         m_user = user_a[w];
         m_rr = (w + 1) % N;
      end else if (bready_i) m_valid = 1'b0;
      #1;
      if (use_model) begin
         chk("bvalid_o", 32'(bvalid_o), 32'(m_valid));
         if (m_valid) begin
            chk("bid_o", 32'(bid_o), 32'(m_id));
            chk("bresp_o", 32'(bresp_o), 32'(m_resp));
            chk("buser_o", 32'(buser_o), 32'(m_user));
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic         br;
      logic [N-1:0] exp_rdy;
      logic         exp_vld;
      logic [2:0]   exp_id;
   } row_t;

   row_t tbl[14];
   logic [N-1:0] seen;
   logic [2:0]   held_id;
   logic [1:0]   held_resp;
   logic [5:0]   held_user;

   initial begin
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'd4};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 3'd5};
      tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 3'd6};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3'd7};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'd4};
      tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd4};
      tbl[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 3'd4};
      tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 3'd4};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd4};
      tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 3'd5};
      tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 3'd5};
      tbl[11] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 3'd6};
      tbl[12] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 3'd7};
      tbl[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 3'd4};

      for (int i = 0; i < N; i++) begin
         bid_a[i]  = {2'(i), 3'(i + 4)};
         resp_a[i] = 2'(i);
         user_a[i] = 6'(i * 9 + 1);
      end
      bready_i = 1'b0;
      rst_n = 1'b0;
      model_reset();

      // Reset held with random requests: nothing may be offered or accepted.
      for (int c = 0; c < 3; c++) begin
         bvalid_i = 4'($urandom);
         @(posedge clk); #1;
         chk("rst_bvalid_o", 32'(bvalid_o), 32'd0);
         chk("rst_bready_o", 32'(bready_o), 32'd0);
      end
      bvalid_i = 4'b0000;
      rst_n = 1'b1;
      tick(1'b1, seen);
      chk("post_rst_bid_o", 32'(bid_o), 32'd0);
      chk("post_rst_bresp_o", 32'(bresp_o), 32'd0);

      // Directed table: fairness, hold, late request, wrap.
      for (int r = 0; r < 14; r++) begin
         bvalid_i = tbl[r].v;
         bready_i = tbl[r].br;
         tick(1'b1, seen);
         chk($sformatf("tbl%0d_rdy", r), 32'(seen), 32'(tbl[r].exp_rdy));
         chk($sformatf("tbl%0d_vld", r), 32'(bvalid_o), 32'(tbl[r].exp_vld));
         if (tbl[r].exp_vld) chk($sformatf("tbl%0d_id", r), 32'(bid_o), 32'(tbl[r].exp_id));
      end

      // Single source, back-to-back beats with routing bits stripped.
      bid_a[2] = {2'b10, 3'h5};
      resp_a[2] = 2'b10;
      bvalid_i = 4'b0100;
      bready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, seen);
         chk("single_rdy", 32'(seen), 32'b0100);
         chk("single_bid", 32'(bid_o), 32'h5);
         chk("single_bresp", 32'(bresp_o), 32'b10);
      end

      // Backpressure: five stalled cycles, then drain and reload in one cycle.
      bready_i = 1'b0;
      held_id = bid_o; held_resp = bresp_o; held_user = buser_o;
      for (int c = 0; c < 5; c++) begin
         bvalid_i = 4'($urandom);
         tick(1'b1, seen);
         chk("bp_rdy", 32'(seen), 32'd0);
         chk("bp_vld", 32'(bvalid_o), 32'd1);
         chk("bp_id", 32'(bid_o), 32'(held_id));
         chk("bp_resp", 32'(bresp_o), 32'(held_resp));
         chk("bp_user", 32'(buser_o), 32'(held_user));
      end
      bvalid_i = 4'b1000;
      bready_i = 1'b1;
      tick(1'b1, seen);
      chk("bp_release_rdy", 32'(seen), 32'b1000);
      chk("bp_release_id", 32'(bid_o), 32'd7);

      // Asynchronous reset while a beat is pending.
      bvalid_i = 4'b1111;
      bready_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_bvalid_o", 32'(bvalid_o), 32'd0);
      chk("arst_bready_o", 32'(bready_o), 32'd0);
      chk("arst_bid_o", 32'(bid_o), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      bready_i = 1'b1;
      tick(1'b1, seen);
      chk("arst_rr0", 32'(seen), 32'b0001);

      // Random traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            bid_a[i]  = 5'($urandom);
            resp_a[i] = 2'($urandom);
            user_a[i] = 6'($urandom);
         end
         bvalid_i = 4'($urandom);
         bready_i = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
         tick(1'b1, seen);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
